// File: rtl/poly_mod_sq_seq_if.sv
// Job, result and squaring-core channels of poly_mod_sq_seq.
// slave = sequencer side, master = scheduler/core environment side.
interface poly_mod_sq_seq_if #(
  parameter int DAT_W     = 85,
  parameter int ITER_BITS = 32,
  parameter int TAG_BITS  = 4
);
  logic                 i_val;
  logic                 o_rdy;
  logic [DAT_W-1:0]     i_dat;
  logic [ITER_BITS-1:0] i_iter;
  logic [TAG_BITS-1:0]  i_tag;
  logic                 o_val;
  logic                 i_rdy;
  logic [DAT_W-1:0]     o_dat;
  logic [TAG_BITS-1:0]  o_tag;
  logic                 o_core_val;
  logic [DAT_W-1:0]     o_core_dat;
  logic                 i_core_val;
  logic [DAT_W-1:0]     i_core_dat;
  logic                 o_err;

  modport slave (
    input  i_val, i_dat, i_iter, i_tag, i_rdy, i_core_val, i_core_dat,
    output o_rdy, o_val, o_dat, o_tag, o_core_val, o_core_dat, o_err
  );

  modport master (
    output i_val, i_dat, i_iter, i_tag, i_rdy, i_core_val, i_core_dat,
    input  o_rdy, o_val, o_dat, o_tag, o_core_val, o_core_dat, o_err
  );
endinterface

// File: rtl/poly_mod_sq_seq.sv
// Multi-slot x^(2^T) sequencer feeding a fixed-latency redundant-form modular squaring core.
// Define POLY_MOD_SQ_SEQ_STATS_EN to add saturating issue/job counters.
module poly_mod_sq_seq #(
  parameter int WORD_BITS       = 16,
  parameter int NUM_WORDS       = 4,
  parameter int REDUN_WORD_BITS = 1,
  parameter int I_WORD          = NUM_WORDS + 1,
  parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter int CORE_LAT        = 5,
  parameter int NUM_SLOTS       = 4,
  parameter int ITER_BITS       = 32,
  parameter int TAG_BITS        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  poly_mod_sq_seq_if.slave bus
`ifdef POLY_MOD_SQ_SEQ_STATS_EN
  ,
  output logic [47:0]      o_stat_issues,
  output logic [31:0]      o_stat_jobs
`endif
);
  localparam int DAT_W  = I_WORD * COEF_BITS;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]           st;
    logic                 pend;
    logic [DAT_W-1:0]     dat;
    logic [ITER_BITS-1:0] rem;
    logic [TAG_BITS-1:0]  tag;
  } slot_t;

  slot_t [NUM_SLOTS-1:0]            slot_q, slot_d;
  logic  [CORE_LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic  [CORE_LAT-1:0]             stale_pipe_q, stale_pipe_d;
  logic  [CORE_LAT-1:0][SLOT_W-1:0] id_pipe_q, id_pipe_d;
  logic                             err_q, err_d;
  logic                             lock_q, lock_d;
  logic  [SLOT_W-1:0]               sel_q, sel_d;

  logic              live, ex_vld, ex_stale, ret_ok, ret_last, fb;
  logic              iss_hit, iss_first, core_val;
  logic              any_idle, any_done, acc, pop, oval;
  logic [SLOT_W-1:0] ex_id, iss_id, acc_id, done_id, out_id;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q       <= '0;
      vld_pipe_q   <= '0;
      stale_pipe_q <= '1;
      id_pipe_q    <= '0;
      err_q        <= 1'b0;
      lock_q       <= 1'b0;
      sel_q        <= '0;
    end else begin
      slot_q       <= slot_d;
      vld_pipe_q   <= vld_pipe_d;
      stale_pipe_q <= stale_pipe_d;
      id_pipe_q    <= id_pipe_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
      sel_q        <= sel_d;
    end
  end

  // Decisions and outputs; everything is gated off during the reset cycle.
  always_comb begin
    live     = ~i_rst;
    ex_vld   = vld_pipe_q[CORE_LAT-1];
    ex_stale = stale_pipe_q[CORE_LAT-1];
    ex_id    = id_pipe_q[CORE_LAT-1];
    ret_ok   = live & ex_vld & bus.i_core_val;
    ret_last = ret_ok && (slot_q[ex_id].rem == ITER_BITS'(1));
    fb       = ret_ok & ~ret_last;
    iss_hit  = 1'b0;
    iss_id   = '0;
    any_idle = 1'b0;
    acc_id   = '0;
    any_done = 1'b0;
    done_id  = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_q[s].st == ST_RUN && slot_q[s].pend) begin
        iss_hit = 1'b1;
        iss_id  = SLOT_W'(s);
      end
      if (slot_q[s].st == ST_IDLE) begin
        any_idle = 1'b1;
        acc_id   = SLOT_W'(s);
      end
      if (slot_q[s].st == ST_DONE) begin
        any_done = 1'b1;
        done_id  = SLOT_W'(s);
      end
    end
    iss_first = live & iss_hit & ~fb;
    core_val  = fb | iss_first;
    // A presented result stays locked until popped, even if a lower slot finishes.
    out_id    = lock_q ? sel_q : done_id;
    oval      = live & (lock_q | any_done);
    acc       = live & any_idle & bus.i_val;
    pop       = oval & bus.i_rdy;

    bus.o_rdy      = live & any_idle;
    bus.o_val      = oval;
    bus.o_dat      = oval ? slot_q[out_id].dat : '0;
    bus.o_tag      = oval ? slot_q[out_id].tag : '0;
    bus.o_core_val = core_val;
    bus.o_core_dat = fb ? bus.i_core_dat : (iss_first ? slot_q[iss_id].dat : '0);
    bus.o_err      = live & err_q;
  end

  always_comb begin
    slot_d = slot_q;
    err_d  = err_q;
    for (int k = CORE_LAT - 1; k > 0; k--) begin
      vld_pipe_d[k]   = vld_pipe_q[k-1];
      stale_pipe_d[k] = stale_pipe_q[k-1];
      id_pipe_d[k]    = id_pipe_q[k-1];
    end
    vld_pipe_d[0]   = core_val;
    stale_pipe_d[0] = 1'b0;
    id_pipe_d[0]    = fb ? ex_id : iss_id;

    // Stale slots cover ops issued before a reset so their late returns are dropped silently.
    if (live && ((ex_vld && !bus.i_core_val) || (!ex_vld && !ex_stale && bus.i_core_val)))
      err_d = 1'b1;

    if (ret_ok) begin
      slot_d[ex_id].dat = bus.i_core_dat;
      slot_d[ex_id].rem = slot_q[ex_id].rem - ITER_BITS'(1);
      if (ret_last) slot_d[ex_id].st = ST_DONE;
    end
    if (iss_first) slot_d[iss_id].pend = 1'b0;
    if (acc) begin
      slot_d[acc_id].st   = (bus.i_iter == '0) ? ST_DONE : ST_RUN;
      slot_d[acc_id].pend = (bus.i_iter != '0);
      slot_d[acc_id].dat  = bus.i_dat;
      slot_d[acc_id].rem  = bus.i_iter;
      slot_d[acc_id].tag  = bus.i_tag;
    end
    if (pop) slot_d[out_id].st = ST_IDLE;

    lock_d = oval & ~bus.i_rdy;
    sel_d  = out_id;
  end

`ifdef POLY_MOD_SQ_SEQ_STATS_EN
  logic [47:0] issues_q, issues_d;
  logic [31:0] jobs_q, jobs_d;

  always_comb begin
    issues_d = issues_q;
    jobs_d   = jobs_q;
    if (core_val && issues_q != '1) issues_d = issues_q + 48'd1;
    if (pop && jobs_q != '1)        jobs_d   = jobs_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issues_q <= '0;
      jobs_q   <= '0;
    end else begin
      issues_q <= issues_d;
      jobs_q   <= jobs_d;
    end
  end

  assign o_stat_issues = issues_q;
  assign o_stat_jobs   = jobs_q;
`endif
endmodule

// File: tb/tb_poly_mod_sq_seq.sv
// Directed bench for poly_mod_sq_seq: Mersenne-61 reference squaring core behind a
// CORE_LAT-deep return pipe, and a tag/value scoreboard checked on every pop.
module tb_poly_mod_sq_seq;
  localparam int CL   = 4;
  localparam int NS   = 4;
  localparam int COEF = 17;
  localparam int IW   = 5;
  localparam int DW   = IW * COEF;
  localparam int IB   = 32;
  localparam int TB   = 4;
  localparam logic [127:0] MOD = (128'd1 << 61) - 128'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_mod_sq_seq_if #(.DAT_W(DW), .ITER_BITS(IB), .TAG_BITS(TB)) bus ();

`ifdef POLY_MOD_SQ_SEQ_STATS_EN
  logic [47:0] stat_issues;
  logic [31:0] stat_jobs;
`endif

  poly_mod_sq_seq #(.CORE_LAT(CL), .NUM_SLOTS(NS), .ITER_BITS(IB), .TAG_BITS(TB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
`ifdef POLY_MOD_SQ_SEQ_STATS_EN
    ,
    .o_stat_issues (stat_issues),
    .o_stat_jobs   (stat_jobs)
`endif
  );

  function automatic logic [127:0] norm(input logic [DW-1:0] d);
    logic [127:0] v = '0;
    for (int i = 0; i < IW; i++) v += 128'(d[i*COEF +: COEF]) << (16 * i);
    return v;
  endfunction

  function automatic logic [127:0] modm(input logic [127:0] x);
    logic [127:0] v = x;
    for (int i = 0; i < 3; i++) v = (v & MOD) + (v >> 61);
    if (v >= MOD) v -= MOD;
    return v;
  endfunction

  function automatic logic [DW-1:0] to_red(input logic [127:0] v);
    logic [DW-1:0] d = '0;
    for (int i = 0; i < IW; i++) d[i*COEF +: COEF] = {1'b0, v[16*i +: 16]};
    return d;
  endfunction

  function automatic logic [DW-1:0] core_sq(input logic [DW-1:0] d);
    logic [127:0] v = modm(norm(d));
    return to_red(modm(v * v));
  endfunction

  function automatic logic [127:0] ref_pow(input logic [127:0] x, input int t);
    logic [127:0] v = modm(x);
    for (int i = 0; i < t; i++) v = modm(v * v);
    return v;
  endfunction

  // Reference core: a result appears exactly CL cycles after its issue.
  logic [CL-1:0] cp_v = '0;
  logic [DW-1:0] cp_d [CL];
  logic          inj_val = 1'b0;
  logic [DW-1:0] inj_dat = '0;
  int            issues = 0;

  always @(posedge clk) begin
    cp_v    <= {cp_v[CL-2:0], bus.o_core_val === 1'b1};
    cp_d[0] <= core_sq(bus.o_core_dat);
    for (int k = 1; k < CL; k++) cp_d[k] <= cp_d[k-1];
    if (bus.o_core_val === 1'b1) issues <= issues + 1;
  end

  assign bus.i_core_val = cp_v[CL-1] | inj_val;
  assign bus.i_core_dat = inj_val ? inj_dat : cp_d[CL-1];

  typedef struct {
    logic [TB-1:0] tag;
    logic [127:0]  val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_val === 1'b1 && bus.i_rdy === 1'b1) begin
      chk("pop_expected", {127'd0, sb.size() != 0}, 128'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_tag", 128'(bus.o_tag), 128'(e.tag));
        chk("pop_val", modm(norm(bus.o_dat)), e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input int t, input logic [TB-1:0] tg);
    bus.i_val  = 1'b1;
    bus.i_dat  = d;
    bus.i_iter = t;
    bus.i_tag  = tg;
  endtask

  task automatic push(input logic [TB-1:0] tg, input logic [127:0] v);
    sb.push_back('{tag: tg, val: v});
  endtask

  task automatic accept(input logic [DW-1:0] d, input int t, input logic [TB-1:0] tg);
    offer(d, t, tg);
    chk("acc_rdy", 128'(bus.o_rdy), 128'd1);
    push(tg, ref_pow(norm(d), t));
    tick();
    bus.i_val = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    chk("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int i0;
    logic [DW-1:0] big;
    bus.i_val  = 1'b0;
    bus.i_dat  = '0;
    bus.i_iter = '0;
    bus.i_tag  = '0;
    bus.i_rdy  = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_o_rdy", 128'(bus.o_rdy), 128'd0);
    chk("rst_o_val", 128'(bus.o_val), 128'd0);
    chk("rst_o_core_val", 128'(bus.o_core_val), 128'd0);
    chk("rst_o_err", 128'(bus.o_err), 128'd0);
    chk("rst_o_dat", 128'(bus.o_dat), 128'd0);
    chk("rst_o_tag", 128'(bus.o_tag), 128'd0);
    chk("rst_o_core_dat", 128'(bus.o_core_dat), 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 128'(bus.o_rdy), 128'd1);

    // T=0: result next cycle, no core traffic
    i0 = issues;
    accept(to_red(3), 0, 4'd5);
    chk("t0_val", 128'(bus.o_val), 128'd1);
    chk("t0_dat", 128'(bus.o_dat), 128'd3);
    chk("t0_tag", 128'(bus.o_tag), 128'd5);
    tick();
    tick();
    chk("t0_issues", 128'(issues - i0), 128'd0);
    drain(10);

    // T=4 latency: o_val first at 1 + T*CL + 1 cycles after accept
    i0 = issues;
    accept(to_red(3), 4, 4'd6);
    n = 1;
    while (bus.o_val !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_lat", 128'(n), 128'(1 + 4 * CL + 1));
    chk("t4_val", modm(norm(bus.o_dat)), 128'd43046721);
    chk("t4_issues", 128'(issues - i0), 128'd4);
    drain(10);

    // Four back-to-back T=100 jobs keep the core busy every cycle
    for (int i = 0; i < IW; i++) big[i*COEF +: COEF] = 17'h1ffff;
    accept(to_red(5), 100, 4'd8);
    i0 = issues;
    accept(to_red(7), 100, 4'd9);
    accept(to_red(11), 100, 4'd10);
    accept(big, 100, 4'd11);
    n = 4;
    while (n < 401) begin
      tick();
      n++;
    end
    chk("tp_issues", 128'(issues - i0), 128'd400);
    drain(50);

    // Backpressure: slots full, presented result held, 5th job waits
    bus.i_rdy = 1'b0;
    push(4'd2, 128'd9);
    push(4'd1, 128'd256);
    push(4'd6, 128'd15);
    push(4'd3, 128'd4);
    push(4'd4, 128'd36);
    offer(to_red(2), 3, 4'd1);
    tick();
    offer(to_red(9), 0, 4'd2);
    tick();
    offer(to_red(4), 0, 4'd3);
    tick();
    offer(to_red(6), 1, 4'd4);
    tick();
    offer(to_red(15), 0, 4'd6);
    for (int c = 4; c < 20; c++) begin
      chk("bp_rdy", 128'(bus.o_rdy), 128'd0);
      chk("bp_val", 128'(bus.o_val), 128'd1);
      chk("bp_tag", 128'(bus.o_tag), 128'd2);
      chk("bp_dat", 128'(bus.o_dat), 128'd9);
      tick();
    end
    bus.i_rdy = 1'b1;
    tick();
    bus.i_rdy = 1'b0;
    chk("bp_free_rdy", 128'(bus.o_rdy), 128'd1);
    chk("bp_next_tag", 128'(bus.o_tag), 128'd1);
    tick();
    bus.i_val = 1'b0;
    chk("bp_refill_rdy", 128'(bus.o_rdy), 128'd0);
    bus.i_rdy = 1'b1;
    drain(20);

    // Spurious core return: sticky error, slot data untouched
    bus.i_rdy = 1'b0;
    accept(to_red(128'h1234), 0, 4'd7);
    chk("inj_err_pre", 128'(bus.o_err), 128'd0);
    inj_dat = to_red(128'd999);
    inj_val = 1'b1;
    tick();
    inj_val = 1'b0;
    chk("inj_err", 128'(bus.o_err), 128'd1);
    chk("inj_dat", 128'(bus.o_dat), 128'(to_red(128'h1234)));
    chk("inj_tag", 128'(bus.o_tag), 128'd7);
    tick();
    tick();
    chk("inj_sticky", 128'(bus.o_err), 128'd1);
    bus.i_rdy = 1'b1;
    drain(10);

    // Mid-run reset with three ops in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_err_clr", 128'(bus.o_err), 128'd0);
    accept(to_red(3), 5, 4'd1);
    accept(to_red(5), 5, 4'd2);
    accept(to_red(7), 5, 4'd3);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_rst_val", 128'(bus.o_val), 128'd0);
    chk("rr_rst_rdy", 128'(bus.o_rdy), 128'd0);
    chk("rr_rst_core", 128'(bus.o_core_val), 128'd0);
    sb.delete();
    i0 = issues;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_val", 128'(bus.o_val), 128'd0);
    chk("rr_rdy", 128'(bus.o_rdy), 128'd1);
    chk("rr_err", 128'(bus.o_err), 128'd0);
    for (int c = 0; c < 8; c++) tick();
    chk("rr_err_late", 128'(bus.o_err), 128'd0);
    chk("rr_val_late", 128'(bus.o_val), 128'd0);
    chk("rr_no_issue", 128'(issues - i0), 128'd0);

    // Normal operation after the flush window
    accept(to_red(5), 2, 4'd9);
    drain(30);
    chk("end_err", 128'(bus.o_err), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
